// File: rtl/hack_cpu_ctrl_pkg.sv
// Shared definitions for the Hack control unit: widths, FSM encoding,
// instruction field positions and a small decode helper.
package hack_cpu_ctrl_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 15;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_WB    = 2'd2;

   localparam int TYPE_BIT = 15;
   localparam int ABIT     = 12;
   localparam int CMP_HI   = 11;
   localparam int CMP_LO   = 6;
   localparam int DEST_HI  = 5;
   localparam int DEST_LO  = 3;
   localparam int JMP_HI   = 2;
   localparam int JMP_LO   = 0;

   typedef struct packed {
      logic       is_c;
      logic       a_sel;
      logic [5:0] comp;
      logic       d_a;
      logic       d_d;
      logic       d_m;
      logic [2:0] jmp;
   } instr_fields_t;

   function automatic instr_fields_t decode(input logic [DATA_W-1:0] w);
      instr_fields_t f;
      f.is_c  = w[TYPE_BIT];
      f.a_sel = w[ABIT];
      f.comp  = w[CMP_HI:CMP_LO];
      f.d_a   = w[DEST_HI];
      f.d_d   = w[DEST_HI-1];
      f.d_m   = w[DEST_LO];
      f.jmp   = w[JMP_HI:JMP_LO];
      return f;
   endfunction

endpackage

// File: rtl/hack_jump_eval.sv
// Jump condition evaluation from {jlt,jeq,jgt} and the captured ALU flags.
module hack_jump_eval (
   input  logic [2:0] j,
   input  logic       zr,
   input  logic       ng,
   output logic       take
);

   assign take = (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack control/register unit: holds A, D, PC and sequences
// FETCH -> EXEC -> (WB) around an external combinational ALU.
module hack_cpu_ctrl
   import hack_cpu_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATA_W-1:0]   instr,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [DATA_W-1:0]   in_m,
   output logic [DATA_W-1:0]   out_m,
   output logic                write_m,
   output logic [ADDR_W-1:0]   address_m,
   output logic [ADDR_W-1:0]   pc,
   output logic [DATA_W-1:0]   alu_x,
   output logic [DATA_W-1:0]   alu_y,
   output logic [5:0]          alu_s,
   input  logic [DATA_W-1:0]   alu_o,
   input  logic                alu_zr,
   input  logic                alu_ng
);

   logic [1:0]        state;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] d_reg;
   logic [DATA_W-1:0] result;
   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] pc_inc;
   logic              flag_zr;
   logic              flag_ng;
   logic              take;
   logic              c_exec;
   logic              in_wb;
   instr_fields_t     f;

   assign f      = decode(ir);
   assign pc_inc = pc_reg + 15'd1;
   assign c_exec = (state == ST_EXEC) && f.is_c;
   assign in_wb  = (state == ST_WB);

   hack_jump_eval u_jump (
      .j    (f.jmp),
      .zr   (flag_zr),
      .ng   (flag_ng),
      .take (take)
   );

   // Handshake: an instruction transfers on a rising edge where both
   // instr_valid and instr_ready are high; instr_ready is high only in FETCH,
   // so instr_valid seen in any other state is ignored and nothing is lost.
   assign instr_ready = (state == ST_FETCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_FETCH;
         ir      <= '0;
         a_reg   <= '0;
         d_reg   <= '0;
         result  <= '0;
         pc_reg  <= '0;
         flag_zr <= 1'b0;
         flag_ng <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (instr_valid) begin
                  ir    <= instr;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (!f.is_c) begin
                  a_reg  <= {1'b0, ir[ADDR_W-1:0]};
                  pc_reg <= pc_inc;
                  state  <= ST_FETCH;
               end else begin
                  result  <= alu_o;
                  flag_zr <= alu_zr;
                  flag_ng <= alu_ng;
                  state   <= ST_WB;
               end
            end
            ST_WB: begin
               // Jump target uses A as it stood before this writeback.
               if (f.d_a) a_reg <= result;
               if (f.d_d) d_reg <= result;
               pc_reg <= take ? a_reg[ADDR_W-1:0] : pc_inc;
               state  <= ST_FETCH;
            end
            default: state <= ST_FETCH;
         endcase
      end
   end

   assign pc        = pc_reg;
   assign address_m = a_reg[ADDR_W-1:0];
   assign write_m   = in_wb && f.d_m;
   assign out_m     = (in_wb && f.d_m) ? result : '0;

   assign alu_x = d_reg;
   assign alu_y = (c_exec && f.a_sel) ? in_m : a_reg;
   assign alu_s = c_exec ? f.comp : 6'd0;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Randomized scoreboard bench for hack_cpu_ctrl with a behavioural Hack
// machine model, an external ALU and a 32K-word data memory.
module tb_hack_cpu_ctrl;

   logic        clk;
   logic        rst_n;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] in_m;
   logic [15:0] out_m;
   logic        write_m;
   logic [14:0] address_m;
   logic [14:0] pc;
   logic [15:0] alu_x;
   logic [15:0] alu_y;
   logic [5:0]  alu_s;
   logic [15:0] alu_o;
   logic        alu_zr;
   logic        alu_ng;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] mem   [0:32767];
   logic [15:0] m_mem [0:32767];

   // {alu_s, alu_x, alu_y} in EXEC; {pc, A[14:0], D} on return to FETCH;
   // {address, data} per memory write.
   logic [37:0] ops_q[$];
   logic [45:0] st_q[$];
   logic [30:0] wr_q[$];

   int          m_pc;
   logic [15:0] m_a;
   logic [15:0] m_d;

   bit mon_en    = 0;
   bit busy      = 0;
   bit exec_next = 0;

   hack_cpu_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .in_m        (in_m),
      .out_m       (out_m),
      .write_m     (write_m),
      .address_m   (address_m),
      .pc          (pc),
      .alu_x       (alu_x),
      .alu_y       (alu_y),
      .alu_s       (alu_s),
      .alu_o       (alu_o),
      .alu_zr      (alu_zr),
      .alu_ng      (alu_ng)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] s);
      logic [15:0] xx, yy, o;
      xx = s[5] ? 16'd0 : x;
      xx = s[4] ? ~xx : xx;
      yy = s[3] ? 16'd0 : y;
      yy = s[2] ? ~yy : yy;
      o  = s[1] ? (xx + yy) : (xx & yy);
      return s[0] ? ~o : o;
   endfunction

   assign alu_o  = hack_alu(alu_x, alu_y, alu_s);
   assign alu_zr = (alu_o == 16'd0);
   assign alu_ng = alu_o[15];
   assign in_m   = mem[address_m];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Architectural model of one Hack instruction.
   task automatic model_step(input logic [15:0] w);
      logic [15:0] y, res;
      int          nxt;
      bit          zr, ng, tk;
      if (!w[15]) begin
         ops_q.push_back({6'd0, m_d, m_a});
         m_a  = {1'b0, w[14:0]};
         m_pc = (m_pc + 1) % 32768;
      end else begin
         y   = w[12] ? m_mem[m_a[14:0]] : m_a;
         res = hack_alu(m_d, y, w[11:6]);
         ops_q.push_back({w[11:6], m_d, y});
         zr  = (res == 16'd0);
         ng  = ($signed(res) < 0);
         tk  = (w[2] && ng) || (w[1] && zr) || (w[0] && !zr && !ng);
         nxt = tk ? int'(m_a[14:0]) : (m_pc + 1) % 32768;
         if (w[3]) begin
            wr_q.push_back({m_a[14:0], res});
            m_mem[m_a[14:0]] = res;
         end
         if (w[5]) m_a = res;
         if (w[4]) m_d = res;
         m_pc = nxt;
      end
      st_q.push_back({m_pc[14:0], m_a[14:0], m_d});
   endtask

   task automatic drive(input logic [15:0] w, input bit hold);
      int n = 0;
      instr       = w;
      instr_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (instr_ready) break;
         n++;
         if (n > 8) begin
            chk("accept_timeout", 64'd1, 64'd0);
            return;
         end
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         instr_valid = 1'b0;
         instr       = 16'(($urandom));
      end
   endtask

   task automatic issue(input logic [15:0] w, input bit hold);
      model_step(w);
      drive(w, hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
   endtask

   // Monitor: observes the DUT on the falling edge and pops expectations.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (exec_next) begin
            exec_next = 0;
            if (ops_q.size() == 0) chk("ops_underflow", 64'd1, 64'd0);
            else begin
               logic [37:0] e;
               e = ops_q.pop_front();
               chk("exec_alu_s", 64'(alu_s), 64'(e[37:32]));
               chk("exec_alu_x", 64'(alu_x), 64'(e[31:16]));
               chk("exec_alu_y", 64'(alu_y), 64'(e[15:0]));
            end
         end
         if (write_m) begin
            if (wr_q.size() == 0) chk("unexpected_write", 64'(address_m), 64'h7fffffff);
            else begin
               logic [30:0] e;
               e = wr_q.pop_front();
               chk("write_addr", 64'(address_m), 64'(e[30:16]));
               chk("write_data", 64'(out_m), 64'(e[15:0]));
            end
            mem[address_m] = out_m;
         end
         if (instr_ready) begin
            if (busy) begin
               busy = 0;
               if (st_q.size() == 0) chk("state_underflow", 64'd1, 64'd0);
               else begin
                  logic [45:0] e;
                  e = st_q.pop_front();
                  chk("arch_pc", 64'(pc), 64'(e[45:31]));
                  chk("arch_a", 64'(address_m), 64'(e[30:16]));
                  chk("arch_d", 64'(alu_x), 64'(e[15:0]));
               end
            end
            if (instr_valid) begin
               busy      = 1;
               exec_next = 1;
            end
         end
      end
   end

   initial begin
      logic [15:0] mem5_init;
      logic [15:0] r;
      rst_n       = 1'b0;
      instr       = 16'd0;
      instr_valid = 1'b0;
      for (int i = 0; i < 32768; i++) begin
         mem[i]   = 16'(($urandom));
         m_mem[i] = mem[i];
      end
      mem5_init = mem[5];
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pc", 64'(pc), 64'd0);
      chk("rst_addr", 64'(address_m), 64'd0);
      chk("rst_d", 64'(alu_x), 64'd0);
      chk("rst_ready", 64'(instr_ready), 64'd1);
      chk("rst_write_m", 64'(write_m), 64'd0);
      chk("rst_out_m", 64'(out_m), 64'd0);
      chk("rst_alu_s", 64'(alu_s), 64'd0);
      rst_n = 1'b1;

      // Reset asserted in the WB cycle of M=D+1 at @5.
      drive(16'h0005, 0);
      drive(16'hE7C8, 0);
      @(negedge clk);
      chk("mid_exec_alu_s", 64'(alu_s), 64'h1F);
      chk("mid_exec_ready", 64'(instr_ready), 64'd0);
      @(negedge clk);
      chk("mid_wb_write_m", 64'(write_m), 64'd1);
      chk("mid_wb_out_m", 64'(out_m), 64'd1);
      chk("mid_wb_addr", 64'(address_m), 64'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_drop_write_m", 64'(write_m), 64'd0);
      chk("rst_async_pc", 64'(pc), 64'd0);
      chk("rst_async_addr", 64'(address_m), 64'd0);
      chk("rst_async_ready", 64'(instr_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_no_mem_write", 64'(mem[5]), 64'(mem5_init));
      chk("rst_d_after", 64'(alu_x), 64'd0);

      m_pc   = 0;
      m_a    = 16'd0;
      m_d    = 16'd0;
      mon_en = 1;

      issue(16'h1234, 0);
      issue(16'h0005, 0);
      issue(16'hEC10, 0);
      issue(16'hE7C8, 0);
      issue(16'hEA90, 0);
      issue(16'h0040, 0);
      issue(16'hE302, 0);
      issue(16'hEE90, 0);
      issue(16'hE301, 0);
      issue(16'h0123, 0);
      issue(16'hEA87, 0);
      issue(16'h0010, 0);
      issue(16'hEDE7, 0);
      issue(16'h7FFF, 0);
      issue(16'hEA87, 0);
      issue(16'h0003, 0);
      // Back-to-back stream with instr_valid held high through EXEC and WB.
      issue(16'h0007, 1);
      issue(16'hEC10, 1);
      issue(16'hE7C8, 1);
      issue(16'h0002, 1);
      issue(16'hFC88, 0);

      for (int k = 0; k < 250; k++) begin
         r = 16'(($urandom));
         if ($urandom_range(0, 2) == 0) r[15] = 1'b0;
         else r[15:13] = 3'b111;
         issue(r, ($urandom_range(0, 1) == 1) && (k != 249));
      end

      instr_valid = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!busy) break;
      end
      @(negedge clk);
      chk("drain_busy", 64'(busy), 64'd0);
      chk("ops_left", 64'(ops_q.size()), 64'd0);
      chk("state_left", 64'(st_q.size()), 64'd0);
      chk("writes_left", 64'(wr_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hack_cpu_ctrl.md
# hack_cpu_ctrl

Multi-cycle control and register unit for the Hack-style datapath. It accepts 16-bit Hack instructions over a valid/ready handshake and holds the A, D and PC registers. It drives the six control bits and both operands of the external 16-bit ALU, consumes the ALU's result, zr and ng, and performs register/memory writeback and jump evaluation.

## Interface
- No parameters; data width fixed at 16, address/PC width fixed at 15.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- instr  input  16  instruction word.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  unit accepts an instruction this cycle.
- in_m  input  16  memory read data at address_m.
- out_m  output  16  memory write data.
- write_m  output  1  memory write strobe, one-cycle pulse.
- address_m  output  15  memory address, equal to A[14:0].
- pc  output  15  current program counter.
- alu_x  output  16  ALU x operand.
- alu_y  output  16  ALU y operand.
- alu_s  output  6  ALU control {zx,nx,zy,ny,f,no}, with zx at bit 5 and no at bit 0.
- alu_o  input  16  ALU result.
- alu_zr  input  1  ALU result-is-zero flag.
- alu_ng  input  1  ALU result-is-negative flag.

## Operation
- State machine FETCH → EXEC → (WB) → FETCH.
  - Reset state: FETCH.
  - Reset values: A=0, D=0, PC=0, IR=0, result=0, flags=0, write_m=0, out_m=0.
- FETCH
  - instr_ready=1; in all other states instr_ready=0.
  - When instr_valid=1, latch IR←instr and go to EXEC. Otherwise stay in FETCH.
- EXEC, A-instruction (IR[15]=0)
  - A←{0,IR[14:0]}, PC←PC+1, go to FETCH.
- EXEC, C-instruction (IR[15]=1)
  - Drive alu_x=D.
  - Drive alu_y = IR[12] ? in_m : A.
  - Drive alu_s=IR[11:6].
  - Capture result←alu_o and flags←{alu_zr,alu_ng}, then go to WB.
- alu_s=0, alu_x=D, alu_y=A in every state except C-instruction EXEC.
- WB
  - Destination bits IR[5:3] = {dA,dD,dM}.
  - If dA: A←result. If dD: D←result.
  - If dM: write_m=1 and out_m=result, with address_m equal to the A value held before this write.
  - Jump bits IR[2:0] = {jlt,jeq,jgt}.
  - take = (jlt&ng) | (jeq&zr) | (jgt&~zr&~ng).
  - If take: PC←A[14:0], using the A value from before this write. Otherwise PC←PC+1.
  - Go to FETCH.
- PC arithmetic is modulo 2^15: 0x7FFF+1 wraps to 0x0000.
- Simultaneous dA and jump: the jump target is the old A; the new A becomes visible in the next instruction.
- Reset asserted mid-instruction
  - All registers return to reset values immediately.
  - Any pending write_m is dropped.
  - The partially executed instruction has no architectural effect.

## Timing
- A-instruction: 2 cycles from acceptance to next instr_ready.
- C-instruction: 3 cycles from acceptance to next instr_ready.
- The ALU path is combinational.
  - alu_x, alu_y and alu_s are valid from the start of EXEC.
  - alu_o, alu_zr and alu_ng are sampled at the end of EXEC.
  - in_m must be stable during EXEC.
- write_m is high for exactly the WB cycle of an instruction with dM=1; out_m and address_m are stable during that cycle.
- pc updates at the end of EXEC (A-instruction) or WB (C-instruction); otherwise it holds.
- instr_valid held high across non-FETCH cycles is ignored; no instruction is lost or duplicated.

## Structure
- Shared package holds:
  - state encoding FETCH/EXEC/WB;
  - instruction field positions: TYPE=15, ABIT=12, CMP=11:6, DEST=5:3, JMP=2:0;
  - widths DATA_W=16 and ADDR_W=15.
- One sub-module: hack_jump_eval, combinational.
  - Inputs: j[2:0], zr, ng.
  - Output: take.
- Registers, FSM and operand muxing live in the top.

## Test plan
- Reset: drive rst_n=0 mid-WB of a dM instruction → write_m drops to 0 immediately; pc=0, A=0, D=0 after release, FETCH with instr_ready=1.
- A-instruction 0x1234 → A=0x1234, address_m=0x1234, pc 0→1 two cycles after acceptance.
- @5, D=A (0xEC10), M=D+1 (0xE7C8) → alu_s=0x1F in EXEC, write_m pulse with out_m=6 at address_m=5, D=5.
- Jumps:
  - D=0 with D;JEQ (0xE302) and A=0x0040 → pc=0x0040.
  - D=0xFFFF with D;JGT → pc increments.
  - 0;JMP (0xEA87) → always taken.
- Simultaneous write and jump: A=0x0010, instruction A=A+1;JMP (0xEDE7) → pc=0x0010 and A=0x0011 after WB.
- Wrap and handshake:
  - pc=0x7FFF with an A-instruction → pc=0x0000.
  - instr_valid held high through EXEC and WB → each instruction accepted once, only in FETCH.
